oam_dma_ctrl: RTL and testbench

OAM_DMA_CTRL -- requirements
Module: oam_dma_ctrl

---
 rtl/oam_dma_ctrl.sv | 122 ++++++++++++
 tb/tb_oam_dma_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/oam_dma_ctrl.sv
// Sprite OAM DMA: a CPU write to P_trig_addr halts the CPU and copies page {page,00..FF} to P_dst_addr.
// Outputs registered; one state step per I_phy2 strobe; I_phy2 low freezes everything.
module oam_dma_ctrl #(
  parameter logic [15:0] P_trig_addr = 16'h4014,
  parameter logic [15:0] P_dst_addr  = 16'h2004
) (
  input  logic        I_clock,
  input  logic        I_reset,
  input  logic        I_phy2,
  input  logic [15:0] I_cpu_addr,
  input  logic        I_cpu_rdwr,
  input  logic [7:0]  I_cpu_wr_data,
  input  logic [7:0]  I_bus_rd_data,
  output logic        O_ready,
  output logic        O_bus_own,
  output logic [15:0] O_addr,
  output logic        O_rdwr,
  output logic [7:0]  O_wr_data,
  output logic        O_busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HALT,
    S_ALIGN,
    S_READ,
    S_WRITE
  } state_t;

  state_t      state_q, state_d;
  logic        parity_q, parity_d;
  logic [7:0]  page_q, page_d;
  logic [7:0]  index_q, index_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic        ready_q, ready_d;
  logic        own_q, own_d;
  logic        rdwr_q, rdwr_d;
  logic        busy_q, busy_d;
  logic [15:0] addr_q, addr_d;

  always_comb begin
    state_d   = state_q;
    parity_d  = parity_q;
    page_d    = page_q;
    index_d   = index_q;
    wr_data_d = wr_data_q;
    if (I_phy2) begin
      parity_d = ~parity_q;
      case (state_q)
        S_IDLE: begin
          if (!I_cpu_rdwr && (I_cpu_addr == P_trig_addr)) begin
            page_d  = I_cpu_wr_data;
            index_d = 8'h00;
            state_d = S_HALT;
          end
        end
        S_HALT: begin
          // Reads must land on get cycles; parity after this cycle is ~parity_q.
          if (I_cpu_rdwr) begin
            state_d = parity_q ? S_READ : S_ALIGN;
          end
        end
        S_ALIGN: state_d = S_READ;
        S_READ: begin
          wr_data_d = I_bus_rd_data;
          state_d   = S_WRITE;
        end
        S_WRITE: begin
          index_d = index_q + 8'h01;
          state_d = (index_q == 8'hFF) ? S_IDLE : S_READ;
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Outputs follow the state being entered so they are registered yet current.
    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
    own_d   = (state_d == S_ALIGN) || (state_d == S_READ) || (state_d == S_WRITE);
    rdwr_d  = (state_d != S_WRITE);
    addr_d  = addr_q;
    if (state_d == S_WRITE) begin
      addr_d = P_dst_addr;
    end else if ((state_d == S_ALIGN) || (state_d == S_READ)) begin
      addr_d = {page_d, index_d};
    end
  end

  always_ff @(posedge I_clock) begin
    if (!I_reset) begin
      state_q   <= S_IDLE;
      parity_q  <= 1'b0;
      page_q    <= 8'h00;
      index_q   <= 8'h00;
      wr_data_q <= 8'h00;
      ready_q   <= 1'b1;
      own_q     <= 1'b0;
      rdwr_q    <= 1'b1;
      busy_q    <= 1'b0;
      addr_q    <= 16'h0000;
    end else begin
      state_q   <= state_d;
      parity_q  <= parity_d;
      page_q    <= page_d;
      index_q   <= index_d;
      wr_data_q <= wr_data_d;
      ready_q   <= ready_d;
      own_q     <= own_d;
      rdwr_q    <= rdwr_d;
      busy_q    <= busy_d;
      addr_q    <= addr_d;
    end
  end

  assign O_ready   = ready_q;
  assign O_bus_own = own_q;
  assign O_addr    = addr_q;
  assign O_rdwr    = rdwr_q;
  assign O_wr_data = wr_data_q;
  assign O_busy    = busy_q;

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Bench for oam_dma_ctrl: host-bus scoreboard of expected DMA cycles plus an idle-state vector table.
module tb_oam_dma_ctrl;
  localparam logic [15:0] TRIG = 16'h4014;
  localparam logic [15:0] DST  = 16'h2004;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        phy2 = 1'b0;
  logic [15:0] cpu_addr = 16'h0000;
  logic        cpu_rdwr = 1'b1;
  logic [7:0]  cpu_wd = 8'h00;
  logic [7:0]  bus_rd;
  logic        ready, own, rdwr, busy;
  logic [15:0] addr;
  logic [7:0]  wr_data;
  logic [27:0] outs;

  oam_dma_ctrl dut (
    .I_clock(clk), .I_reset(rst_n), .I_phy2(phy2), .I_cpu_addr(cpu_addr),
    .I_cpu_rdwr(cpu_rdwr), .I_cpu_wr_data(cpu_wd), .I_bus_rd_data(bus_rd),
    .O_ready(ready), .O_bus_own(own), .O_addr(addr), .O_rdwr(rdwr),
    .O_wr_data(wr_data), .O_busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mem(input logic [15:0] a);
    return a[7:0] ^ 8'h5A;
  endfunction

  assign bus_rd = mem(own ? addr : cpu_addr);
  assign outs   = {ready, own, addr, rdwr, wr_data, busy};

  typedef struct packed {
    logic [15:0] a;
    logic        rw;
    logic [7:0]  d;
    logic        chk;
  } bus_t;

  typedef struct {
    logic [15:0] a;
    logic        rw;
    logic [7:0]  d;
    logic        exp_busy;
  } vec_t;

  bus_t        sb[$];
  int          total = 0;
  int          bad = 0;
  int          stall_cnt = 0;
  int          wr_seen = 0;
  bit          tb_par = 1'b0;
  bit          frz_vld = 1'b0;
  logic [27:0] frz;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic monitor();
    bus_t e;
    if (frz_vld) check("freeze", 32'(outs), 32'(frz));
    if (!ready) stall_cnt++;
    if (own) begin
      if (sb.size() == 0) begin
        check("unexpected_bus_cycle", 32'(addr), 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        check("bus_addr", 32'(addr), 32'(e.a));
        check("bus_rdwr", 32'(rdwr), 32'(e.rw));
        if (e.chk) check("bus_wdata", 32'(wr_data), 32'(e.d));
        if (!e.rw) wr_seen++;
      end
    end
  endtask

  // One CPU cycle: a phy2 clock followed by a phy2-low clock carrying a bogus trigger.
  task automatic cyc(input logic [15:0] a, input logic rw, input logic [7:0] d);
    @(negedge clk);
    cpu_addr = a; cpu_rdwr = rw; cpu_wd = d; phy2 = 1'b1;
    monitor();
    tb_par = ~tb_par;
    @(negedge clk);
    phy2 = 1'b0; cpu_addr = TRIG; cpu_rdwr = 1'b0; cpu_wd = 8'($urandom);
    frz = outs; frz_vld = 1'b1;
  endtask

  task automatic do_reset(input bit with_trig);
    @(negedge clk);
    rst_n = 1'b0;
    if (with_trig) begin
      cpu_addr = TRIG; cpu_rdwr = 1'b0; cpu_wd = 8'h11; phy2 = 1'b1;
    end
    @(negedge clk);
    rst_n = 1'b1; phy2 = 1'b0; cpu_rdwr = 1'b1;
    tb_par = 1'b0; frz_vld = 1'b0;
  endtask

  task automatic start_transfer(input logic [7:0] page, input int n, input bit want_align,
                                output bit align);
    bit par_rd;
    par_rd = tb_par ^ 1'(n + 1);
    if (~par_rd != want_align) cyc(16'h0000, 1'b1, 8'h00);
    stall_cnt = 0;
    wr_seen = 0;
    cyc(TRIG, 1'b0, page);
    for (int k = 0; k < n; k++) cyc(TRIG, 1'b0, 8'(8'h77 + k));
    align = ~tb_par;
    if (align) sb.push_back('{a: {page, 8'h00}, rw: 1'b1, d: 8'h00, chk: 1'b0});
    for (int i = 0; i < 256; i++) begin
      sb.push_back('{a: {page, 8'(i)}, rw: 1'b1, d: 8'h00, chk: 1'b0});
      sb.push_back('{a: DST, rw: 1'b0, d: mem({page, 8'(i)}), chk: 1'b1});
    end
    cyc(16'h8000, 1'b1, 8'h00);
  endtask

  task automatic finish_transfer(input int exp_stall);
    for (int k = 0; k < 700 && busy; k++) cyc(16'h8001, 1'b1, 8'h00);
    check("busy_end", 32'(busy), 32'h0);
    check("ready_end", 32'(ready), 32'h1);
    check("sb_empty", 32'(sb.size()), 32'h0);
    check("stall_cycles", 32'(stall_cnt), 32'(exp_stall));
  endtask

  initial begin
    vec_t vecs[4];
    bit   al;
    vecs[0] = '{a: 16'h4015, rw: 1'b0, d: 8'h02, exp_busy: 1'b0};
    vecs[1] = '{a: 16'h2014, rw: 1'b0, d: 8'h02, exp_busy: 1'b0};
    vecs[2] = '{a: 16'h4014, rw: 1'b1, d: 8'h02, exp_busy: 1'b0};
    vecs[3] = '{a: 16'h4014, rw: 1'b0, d: 8'h02, exp_busy: 1'b1};

    do_reset(1'b0);
    check("rst_ready", 32'(ready), 32'h1);
    check("rst_own", 32'(own), 32'h0);
    check("rst_addr", 32'(addr), 32'h0);
    check("rst_rdwr", 32'(rdwr), 32'h1);
    check("rst_wdata", 32'(wr_data), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);

    for (int r = 0; r < 4; r++) begin
      do_reset(1'b0);
      cyc(vecs[r].a, vecs[r].rw, vecs[r].d);
      check("vec_busy", 32'(busy), 32'(vecs[r].exp_busy));
      check("vec_ready", 32'(ready), 32'(!vecs[r].exp_busy));
      check("vec_own", 32'(own), 32'h0);
    end

    do_reset(1'b1);
    check("rst_prio_busy", 32'(busy), 32'h0);
    check("rst_prio_ready", 32'(ready), 32'h1);

    do_reset(1'b0);
    start_transfer(8'h02, 0, 1'b0, al);
    finish_transfer(513);
    start_transfer(8'h02, 0, 1'b1, al);
    finish_transfer(514);
    start_transfer(8'h03, 0, 1'b0, al);
    finish_transfer(513 + int'(al));
    start_transfer(8'h01, 2, 1'b0, al);
    finish_transfer(515 + int'(al));

    start_transfer(8'h04, 0, 1'b0, al);
    for (int k = 0; k < 300 && wr_seen < 8'h40; k++) cyc(16'h8002, 1'b1, 8'h00);
    cyc(16'h8002, 1'b1, 8'h00);
    check("mid_in_write_rdwr", 32'(rdwr), 32'h0);
    check("mid_in_write_addr", 32'(addr), 32'(DST));
    check("mid_index", 32'(wr_seen), 32'h40);
    do_reset(1'b0);
    check("abort_ready", 32'(ready), 32'h1);
    check("abort_own", 32'(own), 32'h0);
    check("abort_busy", 32'(busy), 32'h0);
    sb.delete();
    for (int k = 0; k < 4; k++) cyc(16'h8003, 1'b1, 8'h00);
    start_transfer(8'h05, 0, 1'b0, al);
    finish_transfer(513);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
